// File: rtl/POLI_types_pkg.sv
// Shared types and default parameter values for the APB wait-state slave.
package POLI_types_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } apb_state_t;

    localparam int unsigned DEF_ADDR_W    = 32;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_NUM_REGS  = 16;
    localparam int unsigned DEF_BASE_ADDR = 0;
    localparam int unsigned DEF_TIMEOUT   = 15;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational word-register address decode: aligned and inside
// [BASE_ADDR, BASE_ADDR + 4*NUM_REGS).
module apb_addr_decode #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned IDX_W     = 4
) (
    input  logic [ADDR_W-1:0] paddr,
    output logic              valid,
    output logic [IDX_W-1:0]  index
);

    logic [ADDR_W-1:0] offset;
    logic              below_base;

    // Extra MSB carries the borrow, so "below base" needs no constant compare.
    assign {below_base, offset} = {1'b0, paddr} - {1'b0, ADDR_W'(BASE_ADDR)};

    assign valid = (paddr[1:0] == 2'b00) && !below_base
                   && ((offset >> 2) < ADDR_W'(NUM_REGS));
    assign index = offset[IDX_W+1:2];

endmodule

// File: rtl/apb_slave_ws.sv
// APB slave bridging to a register backend with wait states and a reg_ack timeout.
// Optional APB_PSTRB_EN adds the PSTRB port and rejects reads carrying strobes.
//
// state | meaning
// IDLE  | waiting for an APB setup phase
// WAIT  | request issued, waiting for reg_ack or timeout (PREADY=0)
// RESP  | one-cycle completion from buffered data/error
// ERR   | one-cycle error completion for a rejected access
module apb_slave_ws
    import POLI_types_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned NUM_REGS  = DEF_NUM_REGS,
    parameter int unsigned BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
    localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int unsigned STRB_W   = DATA_W / 8
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
`ifdef APB_PSTRB_EN
    input  logic [STRB_W-1:0] PSTRB,
`endif
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              reg_req,
    output logic              reg_we,
    output logic [IDX_W-1:0]  reg_index,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [STRB_W-1:0] reg_wstrb,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_ack,
    input  logic              reg_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0] rdata_buf_q, rdata_buf_d;
    logic              err_buf_q, err_buf_d;

    logic              addr_valid;
    logic [IDX_W-1:0]  addr_index;
    logic [STRB_W-1:0] wstrb_in;
    logic              strb_bad;

    apb_addr_decode #(
        .ADDR_W    (ADDR_W),
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_decode (
        .paddr (PADDR),
        .valid (addr_valid),
        .index (addr_index)
    );

`ifdef APB_PSTRB_EN
    assign wstrb_in = PWRITE ? PSTRB : '0;
    assign strb_bad = !PWRITE && (PSTRB != '0);
`else
    assign wstrb_in = PWRITE ? {STRB_W{1'b1}} : '0;
    assign strb_bad = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = 1'b0;
        we_d        = we_q;
        index_d     = index_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_buf_d = rdata_buf_q;
        err_buf_d   = err_buf_q;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    if (addr_valid && !strb_bad) begin
                        state_d = WAIT;
                        req_d   = 1'b1;
                        we_d    = PWRITE;
                        index_d = addr_index;
                        wdata_d = PWDATA;
                        wstrb_d = wstrb_in;
                        cnt_d   = '0;
                    end else begin
                        state_d     = ERR;
                        rdata_buf_d = '0;
                    end
                end
            end
            WAIT: begin
                // Abort beats ack; ack beats a timeout landing in the same cycle.
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (reg_ack) begin
                    if (!we_q) rdata_buf_d = reg_rdata;
                    err_buf_d = reg_err;
                    state_d   = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_buf_d = '0;
                    err_buf_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            index_q     <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_buf_q <= '0;
            err_buf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            index_q     <= index_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_buf_q <= rdata_buf_d;
            err_buf_q   <= err_buf_d;
        end
    end

    assign PREADY    = (state_q == RESP) || (state_q == ERR);
    assign PSLVERR   = ((state_q == RESP) && err_buf_q) || (state_q == ERR);
    assign PRDATA    = rdata_buf_q;
    assign reg_req   = req_q;
    assign reg_we    = we_q;
    assign reg_index = index_q;
    assign reg_wdata = wdata_q;
    assign reg_wstrb = wstrb_q;

endmodule

// File: tb/tb_apb_slave_ws.sv
// Directed bench for apb_slave_ws: wait states, decode errors, timeout, abort, reset.
module tb_apb_slave_ws;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PADDR = '0, PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        reg_req, reg_we;
    logic [3:0]  reg_index;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic [31:0] reg_rdata = '0;
    logic        reg_ack = 1'b0, reg_err = 1'b0;
`ifdef APB_PSTRB_EN
    logic [3:0]  PSTRB = '0;
    logic [3:0]  strb_w = 4'hF, strb_r = 4'h0;
`endif

    int          n_chk = 0, n_bad = 0;
    int          x_wait, x_req;
    logic        x_done, x_err;
    logic [31:0] x_prd, last_wdata, cap_wdata;
    logic        cap_we;
    logic [3:0]  cap_idx, cap_wstrb;

    always #5 CLK = ~CLK;

    apb_slave_ws dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
`ifdef APB_PSTRB_EN
        .PSTRB     (PSTRB),
`endif
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .reg_req   (reg_req),
        .reg_we    (reg_we),
        .reg_index (reg_index),
        .reg_wdata (reg_wdata),
        .reg_wstrb (reg_wstrb),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .reg_err   (reg_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full APB transfer; ack_at is the WAIT cycle (1-based) carrying reg_ack, 0 = never.
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_at, input logic [31:0] rd, input logic er);
        x_req = 0; x_done = 1'b0; x_wait = -1; x_prd = '0; x_err = 1'b0;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
`ifdef APB_PSTRB_EN
        PSTRB = wr ? strb_w : strb_r;
`endif
        @(posedge CLK); #1;
        PENABLE = 1'b1;
        for (int n = 1; n <= 40 && !x_done; n++) begin
            reg_ack = (n == ack_at); reg_rdata = rd; reg_err = er;
            if (n >= 2) PWDATA = 32'hBAD0_0000 ^ 32'(n);
            @(negedge CLK);
            if (reg_req) begin
                x_req++;
                cap_we = reg_we; cap_idx = reg_index; cap_wdata = reg_wdata; cap_wstrb = reg_wstrb;
            end
            if (PREADY) begin
                x_done = 1'b1; x_wait = n - 1; x_prd = PRDATA; x_err = PSLVERR;
            end else begin
                last_wdata = reg_wdata;
            end
            @(posedge CLK); #1;
        end
        reg_ack = 1'b0; reg_err = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        check("ready_seen", 32'(x_done), 32'd1);
    endtask

    initial begin
        #12;
        check("rst_pready", 32'(PREADY), 32'd0);
        check("rst_pslverr", 32'(PSLVERR), 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_req", 32'(reg_req), 32'd0);
        nRST = 1'b1;
        @(posedge CLK); #1;

        // Write with ack in the first WAIT cycle: one wait state.
        do_xfer(1'b1, 32'h8, 32'hDEADBEEF, 1, 32'h0, 1'b0);
        check("wr_wait", 32'(x_wait), 32'd1);
        check("wr_err", 32'(x_err), 32'd0);
        check("wr_nreq", 32'(x_req), 32'd1);
        check("wr_we", 32'(cap_we), 32'd1);
        check("wr_idx", 32'(cap_idx), 32'd2);
        check("wr_wdata", cap_wdata, 32'hDEADBEEF);
        check("wr_wstrb", 32'(cap_wstrb), 32'hF);

        // Read acked in WAIT cycle 5; PWDATA churns but reg_wdata must hold.
        do_xfer(1'b0, 32'h4, 32'h0BADF00D, 5, 32'h12345678, 1'b0);
        check("rd_wait", 32'(x_wait), 32'd5);
        check("rd_data", x_prd, 32'h12345678);
        check("rd_err", 32'(x_err), 32'd0);
        check("rd_we", 32'(cap_we), 32'd0);
        check("rd_idx", 32'(cap_idx), 32'd1);
        check("rd_wstrb", 32'(cap_wstrb), 32'd0);
        check("rd_wdata_hold", last_wdata, 32'h0BADF00D);

        // No ack: timeout after 15 wait cycles, last register index.
        do_xfer(1'b0, 32'h3C, 32'h0, 0, 32'hFFFF_FFFF, 1'b0);
        check("to_wait", 32'(x_wait), 32'd15);
        check("to_err", 32'(x_err), 32'd1);
        check("to_data", x_prd, 32'd0);
        check("to_idx", 32'(cap_idx), 32'd15);
        check("to_nreq", 32'(x_req), 32'd1);

        // Late ack with nothing pending must be ignored.
        reg_ack = 1'b1; reg_err = 1'b1; reg_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("late_ack_ready", 32'(PREADY), 32'd0);
            check("late_ack_prdata", PRDATA, 32'd0);
            @(posedge CLK); #1;
        end
        reg_ack = 1'b0; reg_err = 1'b0;

        // Ack landing in the very last WAIT cycle beats the timeout.
        do_xfer(1'b0, 32'h0, 32'h0, 15, 32'hA5A5_A5A5, 1'b0);
        check("edge_wait", 32'(x_wait), 32'd15);
        check("edge_err", 32'(x_err), 32'd0);
        check("edge_data", x_prd, 32'hA5A5_A5A5);

        // Bad addresses: zero wait states, error, no backend request.
        do_xfer(1'b0, 32'h3, 32'h0, 1, 32'h1111_1111, 1'b0);
        check("mis_wait", 32'(x_wait), 32'd0);
        check("mis_err", 32'(x_err), 32'd1);
        check("mis_data", x_prd, 32'd0);
        check("mis_nreq", 32'(x_req), 32'd0);
        do_xfer(1'b1, 32'h40, 32'h5555_5555, 1, 32'h0, 1'b0);
        check("oor_wait", 32'(x_wait), 32'd0);
        check("oor_err", 32'(x_err), 32'd1);
        check("oor_nreq", 32'(x_req), 32'd0);

        // Backend error passes through with its data.
        do_xfer(1'b0, 32'h1C, 32'h0, 2, 32'h0000_0055, 1'b1);
        check("berr_wait", 32'(x_wait), 32'd2);
        check("berr_err", 32'(x_err), 32'd1);
        check("berr_data", x_prd, 32'h0000_0055);

        // Abort: PSEL drops in WAIT, later ack gets no response.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h20;
        @(posedge CLK); #1; PENABLE = 1'b1;
        @(posedge CLK); #1; PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge CLK); #1; reg_ack = 1'b1; reg_rdata = 32'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("abort_ready", 32'(PREADY), 32'd0);
            check("abort_prdata", PRDATA, 32'h0000_0055);
            @(posedge CLK); #1;
        end
        reg_ack = 1'b0;

        // Reset during WAIT clears everything immediately.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'h1234_ABCD;
        @(posedge CLK); #1; PENABLE = 1'b1;
        #2;
        check("pre_rst_req", 32'(reg_req), 32'd1);
        nRST = 1'b0;
        #1;
        check("mid_rst_req", 32'(reg_req), 32'd0);
        check("mid_rst_we", 32'(reg_we), 32'd0);
        check("mid_rst_idx", 32'(reg_index), 32'd0);
        check("mid_rst_wdata", reg_wdata, 32'd0);
        check("mid_rst_wstrb", 32'(reg_wstrb), 32'd0);
        check("mid_rst_prdata", PRDATA, 32'd0);
        check("mid_rst_pready", 32'(PREADY), 32'd0);
        check("mid_rst_pslverr", 32'(PSLVERR), 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge CLK); #1; nRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("post_rst_req", 32'(reg_req), 32'd0);
            check("post_rst_ready", 32'(PREADY), 32'd0);
            @(posedge CLK); #1;
        end
        do_xfer(1'b1, 32'h3C, 32'h0F0F_0F0F, 1, 32'h0, 1'b0);
        check("after_rst_wait", 32'(x_wait), 32'd1);
        check("after_rst_err", 32'(x_err), 32'd0);
        check("after_rst_nreq", 32'(x_req), 32'd1);
        check("after_rst_wdata", cap_wdata, 32'h0F0F_0F0F);

`ifdef APB_PSTRB_EN
        strb_w = 4'b0101;
        do_xfer(1'b1, 32'h0, 32'h8765_4321, 1, 32'h0, 1'b0);
        check("strb_wstrb", 32'(cap_wstrb), 32'h5);
        check("strb_wr_err", 32'(x_err), 32'd0);
        strb_r = 4'b0001;
        do_xfer(1'b0, 32'h0, 32'h0, 1, 32'h0, 1'b0);
        check("strb_rd_err", 32'(x_err), 32'd1);
        check("strb_rd_wait", 32'(x_wait), 32'd0);
        check("strb_rd_nreq", 32'(x_req), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_slave_ws.md
APB_SLAVE_WS -- requirements
Module: apb_slave_ws

Interface
REQ-001 Parameter: ADDR_W, 32, APB address width.
REQ-002 Parameter: DATA_W, 32, data width; SHALL be a multiple of 8.
REQ-003 Parameter: NUM_REGS, 16, number of word registers decoded.
REQ-004 Parameter: BASE_ADDR, 0, byte address of register 0.
REQ-005 Parameter: TIMEOUT, 15, maximum wait cycles for reg_ack; SHALL be at least 1.
REQ-006 The clock SHALL be CLK, and the reset SHALL be nRST: asynchronous, active-low.
REQ-007 Port: CLK  in  1  clock.
REQ-008 Port: nRST  in  1  asynchronous active-low reset.
REQ-009 Port: PSEL, PENABLE, PWRITE  in  1 each  APB control.
REQ-010 Port: PADDR  in  ADDR_W  APB address.
REQ-011 Port: PWDATA  in  DATA_W  write data.
REQ-012 Port: PSTRB  in  DATA_W/8  byte strobes; present only with APB_PSTRB_EN.
REQ-013 Port: PRDATA  out  DATA_W  read data.
REQ-014 Port: PREADY, PSLVERR  out  1 each  transfer complete / error.
REQ-015 Port: reg_req  out  1  one-cycle request to the register backend.
REQ-016 Port: reg_we  out  1  request is a write.
REQ-017 Port: reg_index  out  $clog2(NUM_REGS)  target register.
REQ-018 Port: reg_wdata  out  DATA_W  write data.
REQ-019 Port: reg_wstrb  out  DATA_W/8  byte enables.
REQ-020 Port: reg_rdata  in  DATA_W  read data, valid with reg_ack.
REQ-021 Port: reg_ack, reg_err  in  1 each  backend completion and error.

Function
REQ-022 The FSM SHALL have the states IDLE, WAIT, RESP and ERR.
REQ-023 Decode: the address SHALL be valid iff PADDR[1:0]==0 and BASE_ADDR <= PADDR < BASE_ADDR+4*NUM_REGS; reg_index = (PADDR-BASE_ADDR)>>2.
REQ-024 In IDLE with PSEL & ~PENABLE and a valid address, the block SHALL assert reg_req for exactly that cycle, drive reg_we/reg_index/reg_wdata from the bus, and go to WAIT.
REQ-025 In IDLE with PSEL & ~PENABLE and an invalid address, the block SHALL go to ERR with no reg_req.
REQ-026 In WAIT, PREADY SHALL be 0; reg_ack SHALL capture reg_rdata (reads only) and reg_err into registered buffers, then go to RESP.
REQ-027 In WAIT, if a wait counter (reset on entry) reaches TIMEOUT without reg_ack, the block SHALL go to RESP with PSLVERR buffer=1 and data buffer=0.
REQ-028 In RESP, PREADY SHALL be 1, PRDATA the data buffer and PSLVERR the error buffer for one cycle, then return to IDLE.
REQ-029 In ERR, PREADY=1, PSLVERR=1 and PRDATA=0 for one cycle, then return to IDLE.
REQ-030 Latency: with reg_ack in the first WAIT cycle, PREADY SHALL rise 2 cycles after the setup cycle (one wait state); a bad address completes with zero wait states.
REQ-031 Outside RESP/ERR, PREADY=0 and PSLVERR=0; PRDATA SHALL hold its last value.
REQ-032 PSEL low in WAIT (protocol abort) SHALL return the FSM to IDLE without a response.
REQ-033 reg_ack outside WAIT SHALL be ignored.
REQ-034 reg_ack in the same cycle the counter reaches TIMEOUT SHALL win (no timeout error).
REQ-035 reg_wdata SHALL be registered at the setup cycle and held stable through WAIT.

Reset
REQ-036 On nRST low, the FSM SHALL go to IDLE, and PREADY, PSLVERR, PRDATA, the counter, both buffers and reg_req SHALL go to 0, immediately and independent of CLK.
REQ-037 Reset mid-transfer SHALL abandon the transfer; no reg_req SHALL be reissued after reset.

Configuration
REQ-038 With APB_PSTRB_EN defined, the PSTRB port SHALL exist; reg_wstrb = PSTRB on writes and 0 on reads; a read with PSTRB != 0 SHALL go to ERR.
REQ-039 Without APB_PSTRB_EN, there SHALL be no PSTRB port; reg_wstrb = all-ones on writes and 0 on reads.

Structure
REQ-040 The apb_state_t enum (IDLE/WAIT/RESP/ERR) and the default parameter constants SHALL be placed in POLI_types_pkg.
REQ-041 Address decode SHALL be a combinational sub-module apb_addr_decode (outputs: valid, index).

Verification
REQ-042 Write 0xDEADBEEF to BASE+0x8 with reg_ack on the first WAIT cycle -> reg_req one cycle, reg_index=2, reg_we=1, PREADY 2 cycles after setup, PSLVERR=0.
REQ-043 Read BASE+0x4 with reg_ack 5 cycles late and reg_rdata=0x12345678 -> PREADY low for 5 cycles, then PRDATA=0x12345678 with PREADY=1.
REQ-044 Access 0x3 (misaligned) and BASE+4*NUM_REGS -> no reg_req, PREADY=1 and PSLVERR=1 on the first access cycle.
REQ-045 Read with no reg_ack -> PSLVERR=1, PRDATA=0 after TIMEOUT=15 cycles; a later reg_ack is ignored.
REQ-046 Assert nRST during WAIT -> all outputs 0 immediately, FSM IDLE; the next transfer completes normally.
REQ-047 With APB_PSTRB_EN, write with PSTRB=4'b0101 -> reg_wstrb=4'b0101; read with PSTRB=4'b0001 -> PSLVERR=1.
